// File: rtl/mmio_responder.sv
// MMIO responder: 16-byte window serving TX byte FIFO, status, synchronized switches, cycle counter.
// Latency: rdata registered one cycle after addr; hit and tx_data/tx_valid are combinational from state.
// Backpressure: tx_valid/tx_ready handshake; a push into a full FIFO without a pop is dropped and sets sticky ovf.
module mmio_responder #(
    parameter logic [31:0] BASE  = 32'hFFFF_FF00,
    parameter int          DEPTH = 8,
    parameter int          SW_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            wen,
    output logic [31:0]     rdata,
    output logic            hit,
    input  logic [SW_W-1:0] sw_in,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_SWITCH = 2'd2;
    localparam logic [1:0] OFF_CYCLES = 2'd3;

    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            wr_q, wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [SW_W-1:0] sw1_q, sw1_d;
    logic [SW_W-1:0] sw2_q, sw2_d;

    logic [1:0]  off;
    logic        wr;
    logic        acc;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_req;
    logic        do_push;
    logic        drop;
    logic [31:0] status;

    assign hit      = (addr[31:4] == BASE[31:4]);
    assign off      = addr[3:2];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign tx_valid = ~empty;
    // Gate the head so an empty FIFO presents zero rather than stale storage.
    assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign rdata    = rdata_q;
    assign status   = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};

    // Write qualification: only the first cycle of a held write to one address takes effect.
    always_comb begin
        wr       = wen & hit;
        acc      = wr & ~(wr_q & (addr == addr_q));
        pop      = tx_valid & tx_ready;
        push_req = acc & (off == OFF_TXDATA);
        // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
        do_push  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_d     = wr;
        addr_d   = addr;
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (acc && (off == OFF_STATUS) && wdata[2]) begin
            ovf_d = 1'b0;
        end
        // Set is applied last so a drop beats a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Free-running counter with load, switch synchronizer and registered read mux.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (acc && (off == OFF_CYCLES)) begin
            cyc_d = wdata;
        end
        sw1_d   = sw_in;
        sw2_d   = sw1_q;
        rdata_d = 32'h0;
        if (hit) begin
            case (off)
                OFF_TXDATA: rdata_d = 32'h0;
                OFF_STATUS: rdata_d = status;
                OFF_SWITCH: rdata_d = 32'(sw2_q);
                OFF_CYCLES: rdata_d = cyc_q;
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    // State registers; reset clears everything including FIFO contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= 32'h0;
            rdata_q  <= 32'h0;
            wr_q     <= 1'b0;
            addr_q   <= 32'h0;
            sw1_q    <= '0;
            sw2_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: scoreboarded reads and TX bytes.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The TX monitor pops expected bytes whenever a handshake is visible.
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;
    logic        hit;
    logic [7:0]  sw_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [31:0] rd_exp [$];
    logic [7:0]  tx_exp [$];

    always #5 clk = ~clk;

    mmio_responder #(.BASE(BASE), .DEPTH(8), .SW_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .wen      (wen),
        .rdata    (rdata),
        .hit      (hit),
        .sw_in    (sw_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] off, input logic [31:0] data, input int hold);
        tick();
        addr  = BASE | {28'b0, off};
        wdata = data;
        wen   = 1'b1;
        repeat (hold) tick();
        wen   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        write_reg(4'h0, {24'b0, b}, 1);
        if (accepted) tx_exp.push_back(b);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] got_exp;
        logic        exp_hit;
        tick();
        addr    = a;
        wen     = 1'b0;
        exp_hit = (a[31:4] == BASE[31:4]);
        rd_exp.push_back(exp);
        @(negedge clk);
        chk({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
        tick();
        @(negedge clk);
        got_exp = rd_exp.pop_front();
        chk(tag, rdata, got_exp);
    endtask

    // TX monitor: every visible handshake must match the next expected byte.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            pops++;
            if (tx_exp.size() == 0) begin
                chk("tx_unexpected_valid", {31'b0, tx_valid}, 32'h0);
            end else begin
                logic [7:0] b;
                b = tx_exp.pop_front();
                chk("tx_byte", {24'b0, tx_data}, {24'b0, b});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int p0;
        rst      = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        wen      = 1'b0;
        sw_in    = 8'h00;
        tx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        tick();
        rst = 1'b1;

        // Status after reset is empty only; counter has advanced three cycles by capture
        read_chk("status_reset", BASE + 32'h4, 32'h0000_0001);
        read_chk("cycles_start", BASE + 32'hC, 32'h0000_0003);
        chk("tx_valid_idle", {31'b0, tx_valid}, 32'h0);

        // Held write pushes exactly once
        write_reg(4'h0, 32'h41, 3);
        tx_exp.push_back(8'h41);
        @(negedge clk);
        chk("held_tx_valid", {31'b0, tx_valid}, 32'h1);
        chk("held_tx_data", {24'b0, tx_data}, 32'h41);
        read_chk("held_status", BASE + 32'h4, 32'h0000_0100);
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("drain1_valid", {31'b0, tx_valid}, 32'h0);

        // Overfill: 9th byte dropped, ovf set
        for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8);
        read_chk("ovf_status", BASE + 32'h4, 32'h0000_0806);
        tick();
        tx_ready = 1'b1;
        p0 = pops;
        repeat (9) @(negedge clk);
        chk("burst_pops", 32'(pops - p0), 32'd8);
        chk("burst_end_valid", {31'b0, tx_valid}, 32'h0);
        tick();
        tx_ready = 1'b0;

        // Clearing ovf through STATUS
        write_reg(4'h4, 32'h0000_0004, 1);
        read_chk("ovf_cleared", BASE + 32'h4, 32'h0000_0001);

        // Full FIFO, push and pop in one cycle
        for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i), 1'b1);
        tick();
        tx_ready = 1'b1;
        addr     = BASE;
        wdata    = 32'hAA;
        wen      = 1'b1;
        tx_exp.push_back(8'hAA);
        tick();
        wen      = 1'b0;
        tx_ready = 1'b0;
        read_chk("full_pushpop_status", BASE + 32'h4, 32'h0000_0802);
        tick();
        tx_ready = 1'b1;
        p0 = pops;
        repeat (9) @(negedge clk);
        chk("pushpop_pops", 32'(pops - p0), 32'd8);
        chk("pushpop_end_valid", {31'b0, tx_valid}, 32'h0);
        chk("tx_queue_left", 32'(tx_exp.size()), 32'd0);
        tick();
        tx_ready = 1'b0;

        // Counter load and wrap on consecutive reads
        write_reg(4'hC, 32'hFFFF_FFFE, 1);
        tick();
        addr = BASE + 32'hC;
        rd_exp.push_back(32'hFFFF_FFFF);
        tick();
        rd_exp.push_back(32'h0000_0000);
        @(negedge clk);
        chk("cyc_wrap_a", rdata, rd_exp.pop_front());
        tick();
        @(negedge clk);
        chk("cyc_wrap_b", rdata, rd_exp.pop_front());

        // Switch synchronizer
        read_chk("switch_zero", BASE + 32'h8, 32'h0);
        tick();
        sw_in = 8'h5A;
        tick();
        read_chk("switch_5a", BASE + 32'h8, 32'h0000_005A);

        // Reads outside the window and of TXDATA
        read_chk("outside", 32'h1000_0004, 32'h0);
        read_chk("txdata_read", BASE + 32'h1, 32'h0);

        // Reset mid-operation discards FIFO contents
        push_byte(8'h77, 1'b1);
        push_byte(8'h78, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, tx_valid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        tx_exp.delete();
        tick();
        rst = 1'b1;
        read_chk("post_rst_status", BASE + 32'h4, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
